// File: rtl/sync_gate_seq_gen_if.sv
// Timing-control and gate-output bundle of the sync/gate/done frame generator.
// The master side drives frame requests and timing; the slave side returns the pulses.
interface sync_gate_seq_gen_if #(
  parameter int NCH    = 2,
  parameter int SYNC_W = 8,
  parameter int CNT_W  = 16
);
  logic                  ena;
  logic                  start;
  logic                  cont;
  logic                  abort;
  logic [SYNC_W-1:0]     Tsync;
  logic [NCH*SYNC_W-1:0] Tgdel;
  logic [NCH*CNT_W-1:0]  Tgate;
  logic [CNT_W-1:0]      Tlen;
  logic                  Sync;
  logic [NCH-1:0]        Gate;
  logic                  Done;
  logic                  busy;

  modport master (
    output ena, start, cont, abort,
    output Tsync, Tgdel, Tgate, Tlen,
    input  Sync, Gate, Done, busy
  );

  modport slave (
    input  ena, start, cont, abort,
    input  Tsync, Tgdel, Tgate, Tlen,
    output Sync, Gate, Done, busy
  );
endinterface

// File: rtl/sync_gate_seq_gen.sv
// Frame generator: Sync pulse, per-channel delayed Gate windows, then Done.
// Outputs are registered from the next-state frame counter and latched timing.
module sync_gate_seq_gen #(
  parameter int NCH    = 2,
  parameter int SYNC_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sync_gate_seq_gen_if.slave     bus
);
  localparam int W2 = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state, n_state;
  logic [CNT_W-1:0]      t, n_t;
  logic [SYNC_W-1:0]     tsync_l, n_tsync;
  logic [NCH*SYNC_W-1:0] tgdel_l, n_tgdel;
  logic [NCH*CNT_W-1:0]  tgate_l, n_tgate;
  logic [CNT_W-1:0]      tlen_l, n_tlen;

  logic                  sync_q, sync_d;
  logic [NCH-1:0]        gate_q, gate_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  latch;
  logic [CNT_W-1:0]      end_t;
  logic [W2-1:0]         tsync_m1;
  logic [W2-1:0]         nt2;
  logic [W2-1:0]         lo, hi;
  logic                  run;

  assign end_t    = (tlen_l == '0) ? '0 : tlen_l - CNT_W'(1);
  assign tsync_m1 = W2'(tsync_l) - W2'(1);

  always_comb begin
    n_state = state;
    n_t     = t;
    n_tsync = tsync_l;
    n_tgdel = tgdel_l;
    n_tgate = tgate_l;
    n_tlen  = tlen_l;
    latch   = 1'b0;
    if (bus.abort) begin
      n_state = IDLE;
      n_t     = '0;
    end else begin
      unique case (state)
        IDLE: latch = bus.start & bus.ena;
        SYNC: if (bus.ena) begin
          n_t = t + CNT_W'(1);
          if (t == end_t)
            n_state = DONE;
          else if (W2'(t) == tsync_m1)
            n_state = RUN;
        end
        RUN: if (bus.ena) begin
          n_t = t + CNT_W'(1);
          if (t == end_t)
            n_state = DONE;
        end
        DONE: begin
          // DONE never pauses: it always lasts exactly one cycle
          if (bus.cont)
            latch = 1'b1;
          else begin
            n_state = IDLE;
            n_t     = '0;
          end
        end
        default: n_state = IDLE;
      endcase
    end
    if (latch) begin
      n_tsync = bus.Tsync;
      n_tgdel = bus.Tgdel;
      n_tgate = bus.Tgate;
      n_tlen  = bus.Tlen;
      n_t     = '0;
      n_state = (bus.Tsync == '0) ? RUN : SYNC;
    end
  end

  // Outputs describe the cycle that begins at the coming edge
  always_comb begin
    run    = (n_state == SYNC) || (n_state == RUN);
    nt2    = W2'(n_t);
    sync_d = run && (nt2 < W2'(n_tsync));
    done_d = (n_state == DONE);
    busy_d = run;
    gate_d = '0;
    lo     = '0;
    hi     = '0;
    for (int i = 0; i < NCH; i++) begin
      lo = W2'(n_tsync) + W2'(n_tgdel[i*SYNC_W +: SYNC_W]);
      hi = lo + W2'(n_tgate[i*CNT_W +: CNT_W]);
      gate_d[i] = run && (nt2 >= lo) && (nt2 < hi)
                  && (n_t < n_tlen);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= '0;
      tsync_l <= '0;
      tgdel_l <= '0;
      tgate_l <= '0;
      tlen_l  <= '0;
      sync_q  <= 1'b0;
      gate_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= n_state;
      t       <= n_t;
      tsync_l <= n_tsync;
      tgdel_l <= n_tgdel;
      tgate_l <= n_tgate;
      tlen_l  <= n_tlen;
      sync_q  <= sync_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Sync = sync_q;
  assign bus.Gate = gate_q;
  assign bus.Done = done_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_sync_gate_seq_gen.sv
// Directed bench for sync_gate_seq_gen with hand-derived per-cycle output vectors.
// Vector layout: {busy, Done, Gate[1], Gate[0], Sync}.
module tb_sync_gate_seq_gen;
  localparam int NCH    = 2;
  localparam int SYNC_W = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  sync_gate_seq_gen_if #(
    .NCH(NCH), .SYNC_W(SYNC_W), .CNT_W(CNT_W)
  ) bus ();

  sync_gate_seq_gen #(
    .NCH(NCH), .SYNC_W(SYNC_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [4:0] obs_vec();
    return {bus.busy, bus.Done, bus.Gate, bus.Sync};
  endfunction

  // T1 frame: Sync t0-2, Gate0 t5-8, Gate1 t8, busy t0-11, Done t12
  function automatic logic [4:0] t1_vec(input int t);
    return {t <= 11, t == 12, t == 8, (t >= 5) && (t <= 8), t < 3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_t1();
    bus.Tsync = 8'd3;
    bus.Tgdel = {8'd5, 8'd2};
    bus.Tgate = {16'd1, 16'd4};
    bus.Tlen  = 16'd12;
    bus.cont  = 1'b0;
    bus.abort = 1'b0;
    bus.ena   = 1'b1;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_t1(input string name);
    load_t1();
    go();
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", name, c), 32'(obs_vec()), 32'(t1_vec(c)));
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.ena   = 1'b1;
    bus.start = 1'b0;
    bus.cont  = 1'b0;
    bus.abort = 1'b0;
    bus.Tsync = '0;
    bus.Tgdel = '0;
    bus.Tgate = '0;
    bus.Tlen  = '0;
    #12;
    chk("reset", 32'(obs_vec()), 32'd0);
    rst_n = 1'b1;
    tick();

    // start with ena low is ignored
    load_t1();
    bus.ena = 1'b0;
    go();
    @(negedge clk);
    chk("start_no_ena", 32'(obs_vec()), 32'd0);
    bus.ena = 1'b1;
    tick();

    run_t1("t1");

    // T2: no Sync, Gate0 clipped at frame end
    bus.Tsync = 8'd0;
    bus.Tgdel = {8'd0, 8'd0};
    bus.Tgate = {16'd0, 16'd20};
    bus.Tlen  = 16'd10;
    go();
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("t2_c%0d", c), 32'(obs_vec()),
          32'({c <= 9, c == 10, 1'b0, c <= 9, 1'b0}));
      tick();
    end

    // T3: continuous mode, Tsync change lands in the next frame
    bus.Tsync = 8'd2;
    bus.Tgdel = '0;
    bus.Tgate = '0;
    bus.Tlen  = 16'd6;
    bus.cont  = 1'b1;
    go();
    for (int c = 0; c <= 22; c++) begin
      int f, fr;
      logic [4:0] e;
      f  = c % 7;
      fr = c / 7;
      if (c >= 21) e = '0;
      else e = {f < 6, f == 6, 2'b00, f < ((fr == 0) ? 2 : 4)};
      @(negedge clk);
      chk($sformatf("t3_c%0d", c), 32'(obs_vec()), 32'(e));
      tick();
      if (c == 0) bus.Tsync = 8'd4;
      if (c == 14) bus.cont = 1'b0;
    end

    // T4: pause for 4 cycles starting at t=4
    load_t1();
    go();
    for (int c = 0; c <= 17; c++) begin
      int te;
      te = (c <= 4) ? c : ((c <= 8) ? 4 : c - 4);
      @(negedge clk);
      chk($sformatf("t4_c%0d", c), 32'(obs_vec()), 32'(t1_vec(te)));
      tick();
      if (c == 3) bus.ena = 1'b0;
      if (c == 7) bus.ena = 1'b1;
    end

    // T5: abort at t=6 with a concurrent start
    load_t1();
    go();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("t5_c%0d", c), 32'(obs_vec()),
          (c <= 6) ? 32'(t1_vec(c)) : 32'd0);
      tick();
      if (c == 5) begin
        bus.abort = 1'b1;
        bus.start = 1'b1;
      end
      if (c == 6) begin
        bus.abort = 1'b0;
        bus.start = 1'b0;
      end
    end

    // T6: async reset mid-Sync, then a clean frame
    load_t1();
    go();
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("t6_c%0d", c), 32'(obs_vec()), 32'(t1_vec(c)));
      if (c < 2) tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async", 32'(obs_vec()), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_idle", 32'(obs_vec()), 32'd0);
    tick();
    run_t1("t6_re");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
